// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          FETCH_XLEN  = 32;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        (push && !clear) |-> (!full || pop));

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : In-order credit-based instruction fetch with redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int BUF_DEPTH       = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int CNT_W  = $clog2(BUF_DEPTH + 2 * MAX_OUTSTANDING + 1) + 1;
    localparam int BUF_CW = $clog2(BUF_DEPTH + 1);
    localparam int OPQ_CW = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_live_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] w_live_nxt;
    logic [CNT_W-1:0] w_drop_nxt;

    logic              w_credit_ok;
    logic              w_slot_ok;
    logic              w_req_fire;
    logic              w_rsp_keep;
    logic              w_rsp_drop;
    logic              w_if_pop;

    logic [XLEN-1:0]   w_opq_head;
    logic [OPQ_CW-1:0] w_opq_count;
    logic              w_opq_empty;
    logic              w_opq_full;

    fetch_entry_t      w_buf_in;
    fetch_entry_t      w_buf_head;
    logic [BUF_CW-1:0] w_buf_count;
    logic              w_buf_empty;
    logic              w_buf_full;

    // Credits come from registered counts only, so a pop this cycle frees nothing yet.
    assign w_credit_ok = (r_live_cnt + CNT_W'(w_buf_count)) < CNT_W'(BUF_DEPTH);
    assign w_slot_ok   = (r_live_cnt + r_drop_cnt) < CNT_W'(MAX_OUTSTANDING);

    assign imem_req_valid = (r_state == FETCH) && !redirect_valid && w_credit_ok && w_slot_ok;
    assign imem_req_addr  = pc_in;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_drop = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_keep = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;

    assign if_valid = !w_buf_empty && !redirect_valid;
    assign w_if_pop = if_valid && if_ready;
    assign if_instr = w_buf_empty ? '0 : w_buf_head.instr;
    assign if_pc    = w_buf_empty ? '0 : w_buf_head.pc;

    always_comb begin
        pc_next = pc_in;
        if (redirect_valid) begin
            pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (w_req_fire) begin
            pc_next = pc_in + XLEN'(INSTR_BYTES);
        end
    end

    always_comb begin
        w_live_nxt = r_live_cnt;
        w_drop_nxt = r_drop_cnt;
        if (redirect_valid) begin
            // Every live request turns stale; a response arriving now is one of them.
            w_live_nxt = '0;
            w_drop_nxt = r_drop_cnt + r_live_cnt - CNT_W'(imem_rsp_valid);
        end else begin
            w_live_nxt = r_live_cnt + CNT_W'(w_req_fire) - CNT_W'(w_rsp_keep);
            w_drop_nxt = r_drop_cnt - CNT_W'(w_rsp_drop);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = (w_drop_nxt != '0) ? FLUSH : FETCH;
        end else begin
            case (r_state)
                BOOT:    w_state_nxt = FETCH;
                FETCH:   w_state_nxt = FETCH;
                FLUSH:   w_state_nxt = (w_drop_nxt == '0) ? FETCH : FLUSH;
                default: w_state_nxt = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= BOOT;
            r_live_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_live_cnt <= w_live_nxt;
            r_drop_cnt <= w_drop_nxt;
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (redirect_valid),
        .push      (w_req_fire),
        .push_data (pc_in),
        .pop       (w_rsp_keep),
        .pop_data  (w_opq_head),
        .count     (w_opq_count),
        .empty     (w_opq_empty),
        .full      (w_opq_full)
    );

    assign w_buf_in.pc    = w_opq_head;
    assign w_buf_in.instr = imem_rsp_data;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_out_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (redirect_valid),
        .push      (w_rsp_keep),
        .push_data (w_buf_in),
        .pop       (w_if_pop),
        .pop_data  (w_buf_head),
        .count     (w_buf_count),
        .empty     (w_buf_empty),
        .full      (w_buf_full)
    );

    a_rsp_expected: assert property (@(posedge clk) disable iff (!reset_n)
        imem_rsp_valid |-> ((r_live_cnt + r_drop_cnt) != '0));
    a_queue_tracks_live: assert property (@(posedge clk) disable iff (!reset_n)
        CNT_W'(w_opq_count) == r_live_cnt);
    a_queue_room: assert property (@(posedge clk) disable iff (!reset_n)
        w_req_fire |-> !w_opq_full);
    a_queue_has_pc: assert property (@(posedge clk) disable iff (!reset_n)
        w_rsp_keep |-> !w_opq_empty);
    a_buf_room: assert property (@(posedge clk) disable iff (!reset_n)
        w_rsp_keep |-> (!w_buf_full || w_if_pop));

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [31:0] pc_reset_val = 32'h0;
    logic        mem_ready = 1'b1;
    int          mem_lat = 1;
    int          edge_n;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    logic [31:0] req_log[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN            (32),
        .BUF_DEPTH       (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc_in          (pc_reg),
        .pc_next        (pc_next),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] got_pc_at(input int i);
        return (got_pc.size() > i) ? got_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] got_instr_at(input int i);
        return (got_instr.size() > i) ? got_instr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] req_at(input int i);
        return (req_log.size() > i) ? req_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] count_seen(input logic [31:0] lo, input logic [31:0] hi);
        int n = 0;
        foreach (got_pc[k]) if (got_pc[k] >= lo && got_pc[k] <= hi) n++;
        return 32'(n);
    endfunction

    // Program-counter register owned by the bench
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc_reg <= pc_reset_val;
        else          pc_reg <= pc_next;
    end

    assign imem_req_ready = mem_ready;

    // In-order memory with fixed latency; presents one response per cycle
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq_addr.delete();
            mq_due.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
            edge_n = 0;
        end else begin
            if (imem_rsp_valid && mq_addr.size() > 0) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(edge_n + mem_lat - 1);
            end
            if (mq_addr.size() > 0 && mq_due[0] <= edge_n) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= instr_of(mq_addr[0]);
            end else begin
                imem_rsp_valid <= 1'b0;
            end
            edge_n++;
        end
    end

    always @(posedge clk) begin
        if (reset_n) begin
            if (if_valid && if_ready) begin
                got_pc.push_back(if_pc);
                got_instr.push_back(if_instr);
            end
            if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
        end
    end

    task automatic clear_logs();
        got_pc.delete();
        got_instr.delete();
        req_log.delete();
    endtask

    // Leaves the bench in the BOOT cycle right after release
    task automatic do_reset(input logic [31:0] pc0);
        @(posedge clk);
        #1;
        pc_reset_val = pc0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_logs();
    endtask

    initial begin
        // Reset values and first fetch
        #1;
        reset_n = 1'b0;
        #2;
        check("rst_if_valid",  32'(if_valid), 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_if_instr",  if_instr, 32'h0);
        check("rst_if_pc",     if_pc, 32'h0);
        check("rst_pc_next",   pc_next, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_logs();
        @(negedge clk);
        check("boot_no_req", 32'(imem_req_valid), 32'h0);
        @(negedge clk);
        check("t1_req_valid", 32'(imem_req_valid), 32'h1);
        check("t1_req_addr",  imem_req_addr, 32'h0);
        check("t1_pc_next",   pc_next, 32'h4);
        repeat (12) @(posedge clk);
        #1;
        check("t1_pc0",    got_pc_at(0), 32'h0);
        check("t1_pc1",    got_pc_at(1), 32'h4);
        check("t1_pc2",    got_pc_at(2), 32'h8);
        check("t1_instr0", got_instr_at(0), instr_of(32'h0));
        check("t1_instr2", got_instr_at(2), instr_of(32'h8));

        // Decode stalled: issue stops at the credit limit
        if_ready = 1'b0;
        do_reset(32'h0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t2_n_req",     32'(req_log.size()), 32'd2);
        check("t2_req0",      req_at(0), 32'h0);
        check("t2_req1",      req_at(1), 32'h4);
        check("t2_req_valid", 32'(imem_req_valid), 32'h0);
        check("t2_pc_next",   pc_next, 32'h8);
        check("t2_if_valid",  32'(if_valid), 32'h1);
        check("t2_hold_pc",   if_pc, 32'h0);
        check("t2_hold_ins",  if_instr, instr_of(32'h0));
        @(posedge clk);
        #1;
        if_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t2_resume",  req_at(2), 32'h8);
        check("t2_out0",    got_pc_at(0), 32'h0);
        check("t2_out1",    got_pc_at(1), 32'h4);

        // Memory not ready: request held stable
        mem_ready = 1'b0;
        do_reset(32'h0);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(imem_req_valid), 32'h1);
            check("t3_hold_addr",  imem_req_addr, 32'h0);
            check("t3_hold_pcnx",  pc_next, 32'h0);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t3_req0", req_at(0), 32'h0);
        check("t3_req1", req_at(1), 32'h4);
        check("t3_out0", got_pc_at(0), 32'h0);

        // Redirect with two requests in flight
        mem_lat = 3;
        do_reset(32'h10);
        @(negedge clk);
        @(negedge clk);
        check("t4_req_a", imem_req_addr, 32'h10);
        @(negedge clk);
        check("t4_req_b", imem_req_addr, 32'h14);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        @(negedge clk);
        check("t4_redir_pcnx", pc_next, 32'h100);
        check("t4_redir_ifv",  32'(if_valid), 32'h0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_flush_a", 32'(imem_req_valid), 32'h0);
        @(negedge clk);
        check("t4_flush_b", 32'(imem_req_valid), 32'h0);
        @(negedge clk);
        check("t4_refetch_v", 32'(imem_req_valid), 32'h1);
        check("t4_refetch_a", imem_req_addr, 32'h100);
        repeat (10) @(posedge clk);
        #1;
        check("t4_first_pc",  got_pc_at(0), 32'h100);
        check("t4_first_ins", got_instr_at(0), instr_of(32'h100));
        check("t4_no_stale",  count_seen(32'h10, 32'h14), 32'h0);

        // Redirect in the same cycle as a response
        mem_lat = 2;
        do_reset(32'h20);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        check("t5_redir_ifv",  32'(if_valid), 32'h0);
        check("t5_redir_pcnx", pc_next, 32'h200);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_flush", 32'(imem_req_valid), 32'h0);
        @(negedge clk);
        check("t5_refetch_v", 32'(imem_req_valid), 32'h1);
        check("t5_refetch_a", imem_req_addr, 32'h200);
        repeat (10) @(posedge clk);
        #1;
        check("t5_first_pc", got_pc_at(0), 32'h200);
        check("t5_no_stale", count_seen(32'h20, 32'h24), 32'h0);

        // Asynchronous reset with the buffer full
        mem_lat  = 1;
        if_ready = 1'b0;
        do_reset(32'h0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t6_full_ifv", 32'(if_valid), 32'h1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_ifv", 32'(if_valid), 32'h0);
        check("t6_async_pc",  if_pc, 32'h0);
        check("t6_async_ins", if_instr, 32'h0);
        mem_ready = 1'b0;
        if_ready  = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_logs();
        @(negedge clk);
        check("t6_boot", 32'(imem_req_valid), 32'h0);
        @(negedge clk);
        check("t6_fetch_v", 32'(imem_req_valid), 32'h1);
        check("t6_fetch_a", imem_req_addr, 32'h0);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_async_req", 32'(imem_req_valid), 32'h0);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // PC increment wraps at the top of the address space
        do_reset(32'hFFFF_FFFC);
        @(negedge clk);
        @(negedge clk);
        check("t7_addr",    imem_req_addr, 32'hFFFF_FFFC);
        check("t7_pc_next", pc_next, 32'h0);
        repeat (8) @(posedge clk);
        #1;
        check("t7_out0", got_pc_at(0), 32'hFFFF_FFFC);
        check("t7_out1", got_pc_at(1), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
